seg_display_rx: RTL and testbench
=================================

Name: seg_display_rx

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the time-multiplexed segment bus (`disp`) and the active-low digit enables (`enable`).
- Decodes each segment pattern back to a digit code and reassembles a 4-digit frame.
- Emits the frame with a one-cycle valid pulse. Used as an on-chip readback/self-check path and as the bench monitor for the calculator top.

Parameters:
- SETTLE, 4: consecutive identical samples of {enable, disp} required before a digit is accepted.
- TIMEOUT, 200000: clk cycles without any accepted digit before `stale` asserts.

Ports:
- clk  in  1  system clock (same domain as the display driver)
- rst  in  1  asynchronous, active-low reset
- disp  in  8  segments, active-low: [6:0]={g,f,e,d,c,b,a}, [7]=dp
- enable  in  4  digit enables, active-low one-hot; bit i = digit i (0 = rightmost)
- digits  out  16  four 4-bit codes, digit i at [4i+3:4i]
- value  out  14  binary value of the frame, 0..9999
- is_neg  out  1  digit 3 decoded as minus
- frame_valid  out  1  one-cycle pulse when digits/value/is_neg update
- err  out  1  sticky; illegal enable or undecodable pattern seen
- stale  out  1  no digit accepted for TIMEOUT cycles
- dp_out  out  4  captured decimal points (optional feature)

Behaviour:
- Reset (rst=0, async): all outputs 0; capture mask 0; settle and timeout counters 0; FSM in COLLECT.
- Sampling: {enable, disp} registered each clk.
  - Settle counter increments while the sample equals the previous sample.
  - It resets to 1 on any change.
  - A digit is accepted on the cycle the counter reaches SETTLE. It is accepted once only, until the sample changes again.
- Enable legality:
  - enable=4'b1111 (all off): ignored; no error.
  - Any pattern other than exactly one zero bit: ignored and sets `err`.
- Decode table (disp[6:0] to code):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9 (hex).
  - 3F→10 (minus), 7F→11 (blank).
  - Anything else → 15 and sets `err`; the digit is still stored.
- Capture:
  - The accepted code is written to the staging slot i and sets mask[i].
  - Re-acceptance of slot i before the frame completes overwrites the slot.
- FSM:
  - COLLECT: when mask==4'b1111 → EMIT.
  - EMIT (one cycle): copy staging to `digits`; compute `value`; set `is_neg`; pulse `frame_valid`; clear mask → COLLECT.
  - Latency: `frame_valid` is high one clk after the fourth distinct digit is accepted.
- Value arithmetic:
  - value = c3·1000 + c2·100 + c1·10 + c0, where codes 10/11/15 count as 0.
  - is_neg = (c3==10).
  - Maximum 9999 fits in 14 bits; no saturation is needed.
- Simultaneous events: acceptance of the fourth digit and an EMIT in progress cannot coincide. If a new acceptance lands in the EMIT cycle, it is applied after the mask clear, so it is not lost.
- Timeout:
  - The counter resets on every acceptance.
  - `stale`=1 when it reaches TIMEOUT; it holds at TIMEOUT (no wrap).
  - `stale` clears on the next acceptance.
- `err` clears only on reset.
- Reset mid-frame discards the partial staging content; outputs return to 0.

Optional Feature:
- Macro: SEG_DISPLAY_RX_DP_EN.
- Defined: disp[7] is captured per slot and latched into `dp_out` at EMIT; dp_out[i]=1 when digit i's dp was lit (disp[7]=0).
- Undefined: disp[7] is ignored and `dp_out` is tied to 0.

Decomposition:
- Shared package seg_pkg holds:
  - segment code constants (SEG_0..SEG_9, SEG_MINUS, SEG_BLANK)
  - digit code constants (DIG_MINUS=10, DIG_BLANK=11, DIG_BAD=15)
  - the 4-bit digit code typedef
  - the FSM state enum (COLLECT, EMIT)
- One sub-module, seg_decode: combinational 7-bit pattern to 4-bit code plus bad flag. It is reusable by the transmit side for self-check.

Test Plan:
- Drive "1234" (enable E,D,B,7 with disp F9,A4,B0,99 reversed to position; 8 cycles each) → one frame_valid; digits=16'h1234; value=1234; is_neg=0; err=0.
- Drive digit3=BF, digits 2..0 = "0","4","2" (C0,99,A4) → value=42; is_neg=1; digits=16'hA042.
- Hold each digit only 3 cycles with SETTLE=4 → no frame_valid; then 4+ cycles → frame within 1 clk of the fourth accept.
- enable=4'b1100 for 10 cycles, then pattern 8'hFE on a valid digit → err=1 sticky; the bad digit decodes to 15; the frame still emits.
- Stop toggling for TIMEOUT cycles (TIMEOUT=50 in bench) → stale=1 at cycle 50; next accepted digit clears it. Assert rst=0 mid-frame → all outputs 0 immediately; the next full frame emits normally.
- With SEG_DISPLAY_RX_DP_EN: digit1 with disp=8'h40 (dp lit, "0") → dp_out=4'b0010. Without the macro → dp_out=0.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the 7-segment display receive path:
//                active-low segment patterns, 4-bit digit codes, the digit
//                code type, the frame-assembly FSM states and a helper that
//                maps a digit code to its numeric weight.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  typedef logic [3:0] digit_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam digit_t DIG_MINUS = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;
  localparam digit_t DIG_BAD   = 4'd15;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // Numeric contribution of a digit: minus, blank and bad codes count as 0
  function automatic digit_t digit_num(input digit_t code);
    return (code <= 4'd9) ? code : 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_decode
//  Description : Combinational 7-segment pattern to digit code decoder.
//                Ports: seg  [6:0] active-low pattern {g,f,e,d,c,b,a}
//                       code [3:0] digit code (0-9, 10 minus, 11 blank, 15 bad)
//                       bad        pattern is not in the table
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output digit_t     code,
  output logic       bad
);

  always_comb begin
    code = DIG_BAD;
    bad  = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_MINUS: code = DIG_MINUS;
      SEG_BLANK: code = DIG_BLANK;
      default:   bad  = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_rx.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_rx
//  Description : Receive side of the multiplexed 7-segment display driver.
//                Debounces {enable, disp}, decodes each settled digit,
//                assembles a 4-digit frame and emits it with a one-cycle
//                frame_valid pulse.
//                Ports: clk, rst (async, active-low)
//                       disp[7:0]    active-low segments, [7] = dp
//                       enable[3:0]  active-low one-hot digit select
//                       digits[15:0] digit i at [4i+3:4i]
//                       value[13:0]  binary value of the frame
//                       is_neg       digit 3 is a minus sign
//                       frame_valid  one-cycle pulse on output update
//                       err          sticky illegal-enable / bad-pattern flag
//                       stale        no digit accepted for TIMEOUT cycles
//                       dp_out[3:0]  captured decimal points
//                Optional feature macro: SEG_DISPLAY_RX_DP_EN (dp capture).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_rx
  import seg_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  disp,
  input  logic [3:0]  enable,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic        is_neg,
  output logic        frame_valid,
  output logic        err,
  output logic        stale,
  output logic [3:0]  dp_out
);

  localparam int             SW       = $clog2(SETTLE + 1);
  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]  SETTLE_C = SW'(SETTLE);
  localparam logic [TW-1:0]  TIMEOUT_C = TW'(TIMEOUT);

  logic [11:0]   r_sample;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_idle;
  digit_t [3:0]  r_stage;
  logic [3:0]    r_mask;
  logic          r_err;
  state_t        r_state;
  state_t        w_state_nxt;
  digit_t [3:0]  r_digits;
  logic [13:0]   r_value;
  logic          r_is_neg;
  logic          r_frame_valid;

  logic [11:0]   w_sample;
  logic          w_same;
  logic [SW-1:0] w_settle_nxt;
  logic          w_settled;
  logic          w_en_off;
  logic          w_en_legal;
  logic          w_accept;
  logic          w_bad_en;
  logic [3:0]    w_slot_oh;
  digit_t        w_code;
  logic          w_code_bad;
  logic          w_emit;
  logic [13:0]   w_value;

  assign w_sample = {enable, disp};
  assign w_same   = (w_sample == r_sample);

  // Run length of identical samples, saturating at SETTLE
  assign w_settle_nxt = !w_same          ? SW'(1) :
                        (r_settle == SETTLE_C) ? r_settle :
                        r_settle + SW'(1);

  // Fires only on the cycle the run length first reaches SETTLE, so a held
  // digit is accepted exactly once
  assign w_settled = (w_settle_nxt == SETTLE_C) && !(w_same && (r_settle == SETTLE_C));

  assign w_en_off   = (enable == 4'b1111);
  assign w_en_legal = $onehot(~enable);
  assign w_slot_oh  = ~enable;
  assign w_accept   = w_settled && w_en_legal;
  assign w_bad_en   = w_settled && !w_en_legal && !w_en_off;

  seg_decode u_decode (
    .seg  (disp[6:0]),
    .code (w_code),
    .bad  (w_code_bad)
  );

  // Outputs are loaded on the COLLECT->EMIT transition so they are already
  // valid during the EMIT cycle in which frame_valid is high
  assign w_emit = (r_state == COLLECT) && (r_mask == 4'b1111);

  assign w_value = 14'(digit_num(r_stage[3])) * 14'd1000
                 + 14'(digit_num(r_stage[2])) * 14'd100
                 + 14'(digit_num(r_stage[1])) * 14'd10
                 + 14'(digit_num(r_stage[0]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (r_mask == 4'b1111) w_state_nxt = EMIT;
      EMIT:    w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample <= '0;
      r_settle <= '0;
      r_idle   <= '0;
      r_stage  <= '0;
      r_mask   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_sample <= w_sample;
      r_settle <= w_settle_nxt;
      if (w_accept) begin
        r_idle <= '0;
      end else if (r_idle != TIMEOUT_C) begin
        r_idle <= r_idle + TW'(1);
      end
      for (int i = 0; i < 4; i++) begin
        if (w_accept && w_slot_oh[i]) r_stage[i] <= w_code;
      end
      // A digit accepted on the emit edge lands after the clear
      r_mask <= (w_emit ? 4'b0000 : r_mask) | (w_accept ? w_slot_oh : 4'b0000);
      if (w_bad_en || (w_accept && w_code_bad)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits      <= '0;
      r_value       <= '0;
      r_is_neg      <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_emit;
      if (w_emit) begin
        r_digits <= r_stage;
        r_value  <= w_value;
        r_is_neg <= (r_stage[3] == DIG_MINUS);
      end
    end
  end

  assign digits      = r_digits;
  assign value       = r_value;
  assign is_neg      = r_is_neg;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;
  assign stale       = (r_idle == TIMEOUT_C);

`ifdef SEG_DISPLAY_RX_DP_EN
  logic [3:0] r_dp_stage;
  logic [3:0] r_dp_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp_stage <= '0;
      r_dp_out   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_accept && w_slot_oh[i]) r_dp_stage[i] <= ~disp[7];
      end
      if (w_emit) r_dp_out <= r_dp_stage;
    end
  end

  assign dp_out = r_dp_out;
`else
  logic w_unused_dp;
  assign w_unused_dp = disp[7];
  assign dp_out      = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_display_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_rx
//  Description : Self-checking bench for seg_display_rx. A cycle-level
//                reference model (run-length settle rule, table decode,
//                slot mask, plain decimal arithmetic) predicts every output
//                each cycle; directed steps also check fixed frame results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_rx;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic        clk;
  logic        rst;
  logic [7:0]  disp;
  logic [3:0]  enable;
  logic [15:0] digits;
  logic [13:0] value;
  logic        is_neg;
  logic        frame_valid;
  logic        err;
  logic        stale;
  logic [3:0]  dp_out;

  seg_display_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .disp        (disp),
    .enable      (enable),
    .digits      (digits),
    .value       (value),
    .is_neg      (is_neg),
    .frame_valid (frame_valid),
    .err         (err),
    .stale       (stale),
    .dp_out      (dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Patterns for codes 0..11 (11 = blank), active-low {g..a}
  logic [6:0] pat [12];
  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2]  = 7'h24; pat[3]  = 7'h30;
    pat[4] = 7'h19; pat[5] = 7'h12; pat[6]  = 7'h02; pat[7]  = 7'h78;
    pat[8] = 7'h00; pat[9] = 7'h10; pat[10] = 7'h3F; pat[11] = 7'h7F;
  end

  int checks;
  int failures;
  int frames_seen;

  // Reference model state
  logic [11:0] m_last;
  int          m_run;
  int          m_idle;
  logic [3:0]  m_mask;
  logic [3:0]  m_stage [4];
  logic [3:0]  m_dp    [4];
  logic [15:0] e_digits;
  int          e_value;
  logic        e_neg;
  logic        e_fv;
  logic        e_err;
  logic [3:0]  e_dp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 12; k++) if (pat[k] == p) return 4'(k);
    return 4'd15;
  endfunction

  function automatic int num(input logic [3:0] c);
    return (c <= 4'd9) ? int'(c) : 0;
  endfunction

  task automatic model_reset();
    m_last = '0; m_run = 0; m_idle = 0; m_mask = '0;
    for (int k = 0; k < 4; k++) begin m_stage[k] = '0; m_dp[k] = '0; end
    e_digits = '0; e_value = 0; e_neg = 0; e_fv = 0; e_err = 0; e_dp = '0;
  endtask

  task automatic model_edge();
    logic [11:0] s;
    int          zeros;
    int          slot;
    logic [3:0]  code;
    bit          took;
    s = {enable, disp};
    if (s == m_last) m_run++; else m_run = 1;
    m_last = s;
    took = 0;
    e_fv = 0;
    if (m_mask == 4'hF) begin
      e_fv     = 1;
      e_digits = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
      e_value  = num(m_stage[3]) * 1000 + num(m_stage[2]) * 100 + num(m_stage[1]) * 10 + num(m_stage[0]);
      e_neg    = (m_stage[3] == 4'd10);
      e_dp     = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      m_mask   = '0;
    end
    if (m_run == SETTLE && enable != 4'hF) begin
      zeros = 0; slot = 0;
      for (int k = 0; k < 4; k++) if (!enable[k]) begin zeros++; slot = k; end
      if (zeros != 1) e_err = 1;
      else begin
        code = ref_decode(disp[6:0]);
        if (code == 4'd15) e_err = 1;
        m_stage[slot] = code;
        m_dp[slot]    = ~disp[7];
        m_mask[slot]  = 1'b1;
        took = 1;
      end
    end
    if (took) m_idle = 0; else m_idle++;
  endtask

  task automatic check_outputs();
    logic [3:0] dp_exp;
`ifdef SEG_DISPLAY_RX_DP_EN
    dp_exp = e_dp;
`else
    dp_exp = 4'b0000;
`endif
    chk("frame_valid", frame_valid, e_fv);
    chk("digits", digits, e_digits);
    chk("value", value, 32'(e_value));
    chk("is_neg", is_neg, e_neg);
    chk("err", err, e_err);
    chk("stale", stale, (m_idle >= TIMEOUT) ? 1'b1 : 1'b0);
    chk("dp_out", dp_out, dp_exp);
  endtask

  // One clock: drive at negedge, model the posedge, check at next negedge
  task automatic step(input logic [3:0] en, input logic [7:0] d);
    enable = en;
    disp   = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (frame_valid) frames_seen++;
    check_outputs();
  endtask

  task automatic hold(input logic [3:0] en, input logic [7:0] d, input int n);
    for (int c = 0; c < n; c++) step(en, d);
  endtask

  // Drives a frame: slot 3 first, each slot held n cycles
  task automatic frame(input logic [7:0] d3, input logic [7:0] d2,
                       input logic [7:0] d1, input logic [7:0] d0, input int n);
    hold(4'b0111, d3, n);
    hold(4'b1011, d2, n);
    hold(4'b1101, d1, n);
    hold(4'b1110, d0, n);
  endtask

  int f0;

  initial begin
    checks = 0; failures = 0; frames_seen = 0;
    rst = 1'b0; enable = 4'hF; disp = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_digits", digits, 16'h0);
    chk("rst_value", value, 14'd0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_stale", stale, 1'b0);
    rst = 1'b1;

    // "1234"
    frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8);
    chk("f1234_count", frames_seen, 1);
    chk("f1234_digits", digits, 16'h1234);
    chk("f1234_value", value, 14'd1234);
    chk("f1234_neg", is_neg, 1'b0);
    chk("f1234_err", err, 1'b0);

    // "-042"
    frame(8'hBF, 8'hC0, 8'h99, 8'hA4, 8);
    chk("fneg_digits", digits, 16'hA042);
    chk("fneg_value", value, 14'd42);
    chk("fneg_neg", is_neg, 1'b1);

    // Short holds never settle, then a long-enough pass emits
    f0 = frames_seen;
    frame(8'h92, 8'h82, 8'hF8, 8'h80, 3);
    frame(8'h92, 8'h82, 8'hF8, 8'h80, 3);
    chk("short_noframe", frames_seen - f0, 0);
    frame(8'h92, 8'h82, 8'hF8, 8'h80, 5);
    chk("long_frame", frames_seen - f0, 1);
    chk("long_digits", digits, 16'h5678);

    // Illegal enable, then an undecodable pattern in slot 1
    hold(4'b1100, 8'hC0, 10);
    chk("illegal_en_err", err, 1'b1);
    frame(8'hF9, 8'hA4, 8'hFE, 8'hB0, 6);
    chk("bad_digits", digits, 16'h12F3);
    chk("bad_value", value, 14'd1203);
    chk("bad_err_sticky", err, 1'b1);

    // Idle until stale, then a new acceptance clears it
    hold(4'b1110, 8'hB0, TIMEOUT + 5);
    chk("stale_set", stale, 1'b1);
    hold(4'b0111, 8'hF9, SETTLE);
    chk("stale_clear", stale, 1'b0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int s = 3; s >= 0; s--) begin
        logic [3:0] code;
        logic [3:0] en;
        code = 4'($urandom_range(0, 11));
        en   = ~(4'b0001 << s);
        hold(en, {1'($urandom_range(0, 1)), pat[code]}, $urandom_range(2, 7));
      end
    end

    // Reset in the middle of a frame
    hold(4'b0111, 8'hC0, 5);
    hold(4'b1011, 8'hF9, 5);
    #2 rst = 1'b0;
    #1;
    chk("midrst_digits", digits, 16'h0);
    chk("midrst_value", value, 14'd0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_neg", is_neg, 1'b0);
    chk("midrst_dp", dp_out, 4'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    f0 = frames_seen;
    frame(8'h90, 8'h80, 8'hF8, 8'h82, 6);
    chk("post_rst_frame", frames_seen - f0, 1);
    chk("post_rst_digits", digits, 16'h9876);
    chk("post_rst_value", value, 14'd9876);

    // Decimal point on digit 1
    frame(8'hF9, 8'hA4, 8'h40, 8'hB0, 6);
`ifdef SEG_DISPLAY_RX_DP_EN
    chk("dp_digit1", dp_out, 4'b0010);
`else
    chk("dp_disabled", dp_out, 4'b0000);
`endif
    chk("dp_frame_digits", digits, 16'h1203);
    hold(4'b1111, 8'hFF, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
